// File: rtl/sreg_pkg.sv
// Shared defaults, beat arithmetic and FSM encoding for the lane deserializer.
// Defining SREG_DESER_PARITY_EN adds the PARITY state used for the trailing parity beat.
package sreg_pkg;

    localparam int SREG_WORD_W = 42;
    localparam int SREG_LANE_W = 2;
    localparam int SREG_BEATS  = SREG_WORD_W / SREG_LANE_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SREG_DESER_PARITY_EN
        , PARITY
`endif
    } state_t;

    // Beat counter width; a single-beat word still needs one counter bit.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sreg_deser_out.sv
// Output stage of the deserializer: pixel register, valid/ready handshake and
// sticky overrun detection for words that complete while the slot is still full.
module sreg_deser_out
    import sreg_pkg::*;
#(
    parameter int WORD_W = SREG_WORD_W
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              word_done,
    input  logic [WORD_W-1:0] word,
    input  logic              pix_ready,
    input  logic              err_clr,
    output logic [WORD_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              overrun
);

    logic [WORD_W-1:0] pix_out_q, pix_out_d;
    logic              pix_valid_q, pix_valid_d;
    logic              overrun_q, overrun_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        pix_out_d   = pix_out_q;
        pix_valid_d = pix_valid_q;
        overrun_d   = overrun_q & ~err_clr;
        if (word_done) begin
            // A completing word may replace one that is being consumed this same cycle.
            if (!pix_valid_q || pix_ready) begin
                pix_out_d   = word;
                pix_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end
    end

    // NOTE: state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/sreg_deser.sv
// Lane deserializer: assembles LANE_W-bit beats (LSB beat first) into WORD_W-bit pixels.
// Optional trailing parity beat when SREG_DESER_PARITY_EN is defined.
module sreg_deser
    import sreg_pkg::*;
#(
    parameter int WORD_W = SREG_WORD_W,
    parameter int LANE_W = SREG_LANE_W
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [LANE_W-1:0] sreg_in,
    input  logic              pix_ready,
    input  logic              err_clr,
    output logic [WORD_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              overrun,
    output logic              short_word,
    output logic              par_err
);

    localparam int               BEATS     = WORD_W / LANE_W;
    localparam int               CNT_W     = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WORD_W-1:0]        acc_q, acc_d;
    logic [WORD_W+LANE_W-1:0] acc_cat;
    logic                     short_word_q, short_word_d;
    logic                     short_set;
    logic                     word_done;
`ifdef SREG_DESER_PARITY_EN
    logic                     par_err_q, par_err_d;
    logic                     par_set;
`endif

    always_ff @(posedge sclk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = SHIFT;
            end
            SHIFT: begin
                if (!load && shift && cnt_q == LAST_BEAT) begin
`ifdef SREG_DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SREG_DESER_PARITY_EN
            PARITY: begin
                if (load)       state_d = SHIFT;
                else if (shift) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // New beats enter at the top so the first beat ends up in the lowest lane.
    assign acc_cat = {sreg_in, acc_q};

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        word_done = 1'b0;
        short_set = 1'b0;
`ifdef SREG_DESER_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load) cnt_d = '0;
            end
            SHIFT: begin
                if (load) begin
                    cnt_d     = '0;
                    short_set = (cnt_q != '0);
                end else if (shift) begin
                    acc_d = acc_cat[WORD_W+LANE_W-1:LANE_W];
                    if (cnt_q == LAST_BEAT) begin
`ifndef SREG_DESER_PARITY_EN
                        cnt_d     = '0;
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SREG_DESER_PARITY_EN
            PARITY: begin
                // The counter still points at the last beat, so a load here is a mid-word restart.
                if (load) begin
                    cnt_d     = '0;
                    short_set = (cnt_q != '0);
                end else if (shift) begin
                    cnt_d = '0;
                    if (sreg_in[0] == ^acc_q) word_done = 1'b1;
                    else                      par_set   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign short_word_d = short_set | (short_word_q & ~err_clr);
`ifdef SREG_DESER_PARITY_EN
    assign par_err_d    = par_set | (par_err_q & ~err_clr);
`endif

    // NOTE: the accumulator is reset along with control so a reset mid-word leaves no stale data.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            short_word_q <= 1'b0;
`ifdef SREG_DESER_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            short_word_q <= short_word_d;
`ifdef SREG_DESER_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign short_word = short_word_q;
`ifdef SREG_DESER_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

    sreg_deser_out #(
        .WORD_W (WORD_W)
    ) u_out (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .word_done (word_done),
        .word      (acc_d),
        .pix_ready (pix_ready),
        .err_clr   (err_clr),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sreg_deser.sv
// Scoreboard bench for sreg_deser: words are sliced into beats by the driver, expected
// deliveries are queued by a handshake-level model and popped by an independent monitor.
module tb_sreg_deser;

    localparam int WORD_W = 42;
    localparam int LANE_W = 2;
    localparam int BEATS  = WORD_W / LANE_W;
`ifdef SREG_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANE_W-1:0] lane_t;

    logic  sclk      = 1'b0;
    logic  rst_n     = 1'b0;
    logic  load      = 1'b0;
    logic  shift     = 1'b0;
    lane_t sreg_in   = '0;
    logic  pix_ready = 1'b0;
    logic  err_clr   = 1'b0;
    word_t pix_out;
    logic  pix_valid;
    logic  overrun;
    logic  short_word;
    logic  par_err;

    sreg_deser #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W)
    ) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .load       (load),
        .shift      (shift),
        .sreg_in    (sreg_in),
        .pix_ready  (pix_ready),
        .err_clr    (err_clr),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .overrun    (overrun),
        .short_word (short_word),
        .par_err    (par_err)
    );

    always #5 sclk = ~sclk;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];
    bit    m_full, m_ovr, m_short, m_par;
    int    m_pending  = 0;   // beats taken since the last load; 0 when no word is open
    int    ready_mode = 1;   // 0: ready low, 1: ready high, 2: random each cycle
    bit    clr_next   = 1'b0;
    bit    mon_en     = 1'b0;
    bit    prev_hold  = 1'b0;
    word_t prev_out   = '0;

    task automatic check_word(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's view of what that edge must do.
    task automatic step(input bit ld, input bit sh, input lane_t d, input bit done,
                        input word_t w, input bit short_evt, input bit par_evt);
        bit clr;
        bit ovr_evt;
        load    = ld;
        shift   = sh;
        sreg_in = d;
        clr      = clr_next;
        clr_next = 1'b0;
        err_clr  = clr;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge sclk);
        ovr_evt = 1'b0;
        if (!rst_n) begin
            m_full  = 1'b0;
            m_ovr   = 1'b0;
            m_short = 1'b0;
            m_par   = 1'b0;
            exp_q.delete();
        end else begin
            if (done) begin
                if (!m_full || pix_ready) begin
                    exp_q.push_back(w);
                    m_full = 1'b1;
                end else begin
                    ovr_evt = 1'b1;
                end
            end else if (m_full && pix_ready) begin
                m_full = 1'b0;
            end
            m_ovr   = ovr_evt   | (m_ovr   & !clr);
            m_short = short_evt | (m_short & !clr);
            m_par   = par_evt   | (m_par   & !clr);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, lane_t'($urandom), 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lane_t'($urandom), 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, lane_t'($urandom), 1'b0, '0, 1'b0, 1'b0);
        rst_n     = 1'b1;
        m_pending = 0;
    endtask

    // Load then n beats of junk, leaving the word open.
    task automatic partial(input int n);
        step(1'b1, 1'b0, lane_t'($urandom), 1'b0, '0, m_pending != 0, 1'b0);
        m_pending = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, lane_t'($urandom), 1'b0, '0, 1'b0, 1'b0);
            m_pending++;
        end
    endtask

    task automatic send_word(input word_t w, input int max_gap, input bit collide, input bit par_ok);
        lane_t pb;
        step(1'b1, collide, lane_t'($urandom), 1'b0, '0, m_pending != 0, 1'b0);
        m_pending = 0;
        for (int b = 0; b < BEATS; b++) begin
            idle($urandom_range(0, max_gap));
            step(1'b0, 1'b1, w[b*LANE_W +: LANE_W], (b == BEATS - 1) && !PAR_EN, w, 1'b0, 1'b0);
            m_pending = b + 1;
        end
        if (PAR_EN) begin
            idle($urandom_range(0, max_gap));
            pb    = lane_t'($urandom);
            pb[0] = par_ok ? ^w : ~(^w);
            step(1'b0, 1'b1, pb, par_ok, w, 1'b0, !par_ok);
        end
        m_pending = 0;
    endtask

    // Monitor: compares outputs and flags against the model, pops on each handshake.
    always @(negedge sclk) begin
        if (mon_en) begin
            if (pix_valid && prev_hold) check_word("hold_stable", pix_out, prev_out);
            check_bit("pix_valid", pix_valid, m_full);
            check_bit("overrun", overrun, m_ovr);
            check_bit("short_word", short_word, m_short);
            check_bit("par_err", par_err, m_par);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h want none (t=%0t)", pix_out, $time);
                end else begin
                    check_word("pix_out", pix_out, exp_q.pop_front());
                end
            end
            prev_hold = pix_valid && !pix_ready;
            prev_out  = pix_out;
        end
    end

    initial begin
        word_t w;
        do_reset();
        mon_en = 1'b1;
        check_word("rst_pix_out", pix_out, '0);
        check_bit("rst_pix_valid", pix_valid, 1'b0);
        check_bit("rst_overrun", overrun, 1'b0);

        // Alternating-bit pattern, ready held high.
        ready_mode = 1;
        send_word(42'h155_5555_5555, 0, 1'b0, 1'b1);
        check_word("alt_word", pix_out, 42'h155_5555_5555);
        idle(2);

        // Second word completes while the first is still held.
        ready_mode = 0;
        send_word(42'h2AA_0F0F_1357, 1, 1'b0, 1'b1);
        send_word(42'h3C3_1111_2222, 1, 1'b0, 1'b1);
        check_word("overrun_hold", pix_out, 42'h2AA_0F0F_1357);
        check_bit("overrun_set", overrun, 1'b1);
        clr_next = 1'b1;
        idle(1);
        ready_mode = 1;
        idle(3);

        // Restart mid-word.
        partial(10);
        send_word(42'h0AB_CDEF_1234, 0, 1'b0, 1'b1);
        check_bit("short_set", short_word, 1'b1);
        check_word("short_word_out", pix_out, 42'h0AB_CDEF_1234);
        idle(2);

        // A new short event in the same cycle as err_clr keeps the flag.
        partial(5);
        clr_next = 1'b1;
        send_word(42'h001_2345_6789, 0, 1'b0, 1'b1);
        check_bit("short_set_wins", short_word, 1'b1);
        clr_next = 1'b1;
        idle(2);

        // load and shift together: the colliding beat must not be taken.
        send_word(42'h3FF_FFFF_FFFE, 0, 1'b1, 1'b1);
        idle(2);

        // Reset mid-word, then a clean word.
        partial(12);
        do_reset();
        send_word(42'h123_4567_89AB, 0, 1'b0, 1'b1);
        idle(2);

`ifdef SREG_DESER_PARITY_EN
        send_word(42'h1, 0, 1'b0, 1'b0);
        check_bit("par_err_set", par_err, 1'b1);
        check_bit("par_no_valid", pix_valid, 1'b0);
        clr_next = 1'b1;
        send_word(42'h1, 0, 1'b0, 1'b1);
        check_word("par_ok_word", pix_out, 42'h1);
        idle(2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            ready_mode = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1)) : 2;
            if ($urandom_range(0, 5) == 0) partial($urandom_range(1, BEATS - 1));
            if ($urandom_range(0, 4) == 0) clr_next = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                partial($urandom_range(1, BEATS - 1));
                do_reset();
            end
            w = word_t'({$urandom, $urandom});
            send_word(w, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 4) != 0));
            idle($urandom_range(0, 3));
        end

        ready_mode = 1;
        idle(4);
        check_int("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
